// File: rtl/hex_word_scroller.sv
// Rotates the message "dE1 " across four HEX digits, one position per
// timebase tick or per rising edge of a manual step input.
module hex_word_scroller #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       dir,
  input  logic       step,
  output logic [7:0] codes,
  output logic [1:0] offset,
  output logic       tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_off;
  logic          r_tick;
  logic          r_step_q;

  logic          w_auto;
  logic          w_step_ev;
  logic          w_adv;
  logic [1:0]    w_next_off;
  logic [1:0]    w_c3;
  logic [1:0]    w_c2;
  logic [1:0]    w_c1;
  logic [1:0]    w_c0;

  assign w_auto     = enable && (r_cnt == CNT_LAST);
  assign w_step_ev  = step && !r_step_q;
  // A coincident auto and step event still moves by a single position.
  assign w_adv      = w_auto || w_step_ev;
  assign w_next_off = dir ? r_off + 2'd1 : r_off - 2'd1;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_cnt    <= '0;
      r_off    <= 2'd0;
      r_tick   <= 1'b0;
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step;
      r_tick   <= w_auto;
      if (enable) begin
        r_cnt <= w_auto ? '0 : r_cnt + CW'(1);
      end
      if (w_adv) begin
        r_off <= w_next_off;
      end
    end
  end

  // HEX i shows message index (offset + 3 - i) mod 4.
  assign w_c3 = r_off;
  assign w_c2 = r_off + 2'd1;
  assign w_c1 = r_off + 2'd2;
  assign w_c0 = r_off + 2'd3;

  assign codes  = {w_c3, w_c2, w_c1, w_c0};
  assign offset = r_off;
  assign tick   = r_tick;

endmodule

// File: tb/tb_hex_word_scroller.sv
// Self-checking bench for hex_word_scroller: directed scenarios plus
// randomized stimulus against a behavioural reference model.
module tb_hex_word_scroller;

  localparam int DIV = 4;

  logic       CLOCK_50;
  logic       reset;
  logic       enable;
  logic       dir;
  logic       step;
  logic [7:0] codes;
  logic [1:0] offset;
  logic       tick;

  int n_tests;
  int n_fail;

  int m_cnt;
  int m_off;
  int m_tick;
  int m_stepq;
  int tick_seen;

  hex_word_scroller #(.TICK_DIV(DIV)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (enable),
    .dir      (dir),
    .step     (step),
    .codes    (codes),
    .offset   (offset),
    .tick     (tick)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_codes(input int off);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[2*i +: 2] = 2'((off + 3 - i) % 4);
    end
    return c;
  endfunction

  // One clock cycle: apply inputs, advance the model, check outputs.
  task automatic cyc(input logic r, input logic e, input logic d,
                     input logic s);
    bit auto_ev;
    bit step_ev;
    reset  = r;
    enable = e;
    dir    = d;
    step   = s;
    if (r) begin
      m_cnt   = 0;
      m_off   = 0;
      m_tick  = 0;
      m_stepq = 0;
    end else begin
      auto_ev = e && (m_cnt == DIV - 1);
      step_ev = s && (m_stepq == 0);
      if (e) m_cnt = (m_cnt + 1) % DIV;
      m_tick = auto_ev ? 1 : 0;
      if (auto_ev || step_ev) m_off = (m_off + (d ? 1 : 3)) % 4;
      m_stepq = s ? 1 : 0;
    end
    @(posedge CLOCK_50);
    #1;
    chk("offset", {6'd0, offset}, 8'(m_off));
    chk("tick", {7'd0, tick}, 8'(m_tick));
    chk("codes", codes, exp_codes(m_off));
    if (tick === 1'b1) tick_seen++;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    tick_seen = 0;
    reset  = 1'b0;
    enable = 1'b0;
    dir    = 1'b0;
    step   = 1'b0;
    @(negedge CLOCK_50);

    // Reset state
    cyc(1, 0, 1, 0);
    chk("rst_codes", codes, 8'b00_01_10_11);
    chk("rst_tick", {7'd0, tick}, 8'd0);

    // Left scroll, 16 enabled cycles
    tick_seen = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 1, 0);
      if (i == 3) chk("codes_off1", codes, 8'b01_10_11_00);
    end
    chk("tick_count16", 8'(tick_seen), 8'd4);
    chk("wrap_left", {6'd0, offset}, 8'd0);

    // Right scroll from reset
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    chk("right_off3", {6'd0, offset}, 8'd3);
    chk("right_codes", codes, 8'b11_00_01_10);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0);
    chk("right_back0", {6'd0, offset}, 8'd0);

    // Held step gives one advance; tick never asserts
    cyc(1, 0, 1, 0);
    tick_seen = 0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    chk("step_twice", {6'd0, offset}, 8'd2);
    chk("step_notick", 8'(tick_seen), 8'd0);

    // Step coincident with auto event
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 1);
    chk("coinc_off", {6'd0, offset}, 8'd1);
    chk("coinc_tick", {7'd0, tick}, 8'd1);
    cyc(0, 1, 1, 0);
    chk("coinc_tick_low", {7'd0, tick}, 8'd0);

    // Disabled cycles keep the partial count
    cyc(1, 0, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    chk("hold_pre", {6'd0, offset}, 8'd0);
    cyc(0, 1, 1, 0);
    chk("hold_adv", {6'd0, offset}, 8'd1);

    // Mid-operation reset at cnt=2, offset=2, with step in reset cycle
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0);
    chk("pre_rst_off", {6'd0, offset}, 8'd2);
    cyc(1, 1, 1, 1);
    chk("mid_rst_off", {6'd0, offset}, 8'd0);
    chk("mid_rst_codes", codes, 8'b00_01_10_11);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0);
    chk("post_rst_wait", {6'd0, offset}, 8'd0);
    cyc(0, 1, 1, 0);
    chk("post_rst_adv", {6'd0, offset}, 8'd1);

    // Randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
